dffsnq_preset_sequencer: RTL and testbench

- Drives the active-low SETN pins of a bank of set-able D flip-flops, split into NGRP groups.
- On request, presets the groups one at a time with a staggered, non-overlapping pulse to limit simultaneous switching current.
- Gates the bank's functional clock while a sequence is running.
- Completes a four-phase REQ/ACK handshake with the power/mode controller that owns the bank.

---
 rtl/dffsnq_preset_sequencer_if.sv | 22 ++
 rtl/dffsnq_preset_sequencer.sv | 145 ++++++++++++++
 tb/tb_dffsnq_preset_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dffsnq_preset_sequencer_if.sv
// Handshake and SETN bus between the power/mode controller and the preset
// sequencer. The controller side drives REQ and observes everything else.
interface dffsnq_preset_sequencer_if #(
  parameter int unsigned NGRP = 4
) ();
  logic            req;
  logic            ack;
  logic            busy;
  logic            clk_en;
  logic [NGRP-1:0] setn;
  logic [3:0]      cur_grp;

  modport master (
    output req,
    input  ack, busy, clk_en, setn, cur_grp
  );

  modport slave (
    input  req,
    output ack, busy, clk_en, setn, cur_grp
  );
endinterface

// File: rtl/dffsnq_preset_sequencer.sv
// Preset sequencer for a bank of set-able flops: pulses each group's
// active-low SETN in turn (HOLD cycles low, GAP cycles settle), gates the
// bank clock while running and closes a four-phase REQ/ACK handshake.
module dffsnq_preset_sequencer #(
  parameter int unsigned NGRP = 4,
  parameter int unsigned HOLD = 3,
  parameter int unsigned GAP  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  dffsnq_preset_sequencer_if.slave   bus
);

  localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int unsigned CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [GW-1:0] GRP_LAST  = GW'(NGRP - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [GW-1:0]   grp, grp_n;
  logic [CW-1:0]   cnt, cnt_n;

  logic [NGRP-1:0] setn_n;
  logic            ack_n;
  logic            busy_n;
  logic            clk_en_n;
  logic [3:0]      cur_grp_n;

  // State, group index and cycle counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      grp   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      grp   <= grp_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state sequencing through the groups.
  always_comb begin
    state_n = state;
    grp_n   = grp;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: begin
        if (bus.req) begin
          state_n = S_ASSERT;
          grp_n   = '0;
          cnt_n   = '0;
        end
      end
      S_ASSERT: begin
        if (cnt == HOLD_LAST) begin
          cnt_n = '0;
          if (GAP > 0) begin
            state_n = S_GAP;
          end else if (grp == GRP_LAST) begin
            state_n = S_DONE;
            grp_n   = '0;
          end else begin
            grp_n   = grp + GW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (grp == GRP_LAST) begin
            state_n = S_DONE;
            grp_n   = '0;
          end else begin
            state_n = S_ASSERT;
            grp_n   = grp + GW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DONE: begin
        if (!bus.req) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        grp_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered and
  // still line up with the state they describe (no glitches on SETN).
  always_comb begin
    setn_n    = '1;
    ack_n     = 1'b0;
    busy_n    = 1'b0;
    clk_en_n  = 1'b1;
    cur_grp_n = '0;
    if (state_n == S_ASSERT) begin
      setn_n[grp_n] = 1'b0;
    end
    if (state_n == S_ASSERT || state_n == S_GAP) begin
      busy_n    = 1'b1;
      clk_en_n  = 1'b0;
      cur_grp_n = 4'(grp_n);
    end
    if (state_n == S_DONE) begin
      ack_n = 1'b1;
    end
  end

  // Registered outputs; reset releases every SETN pin immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.setn    <= '1;
      bus.ack     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.clk_en  <= 1'b1;
      bus.cur_grp <= '0;
    end else begin
      bus.setn    <= setn_n;
      bus.ack     <= ack_n;
      bus.busy    <= busy_n;
      bus.clk_en  <= clk_en_n;
      bus.cur_grp <= cur_grp_n;
    end
  end

endmodule

// File: tb/tb_dffsnq_preset_sequencer.sv
// Bench for the preset sequencer: two instances (default timing and
// HOLD=1/GAP=0) share REQ/RST and are compared every cycle against a
// timeline model that derives outputs from cycles elapsed since start.
module tb_dffsnq_preset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  // model: 0 idle, 1 running (t = cycles since start edge), 2 done
  int mode [2];
  int t    [2];
  int hold [2] = '{3, 1};
  int gap  [2] = '{2, 0};
  int ngrp = 4;

  dffsnq_preset_sequencer_if #(.NGRP(4)) bus0 ();
  dffsnq_preset_sequencer_if #(.NGRP(4)) bus1 ();

  assign bus0.req = req;
  assign bus1.req = req;

  dffsnq_preset_sequencer #(.NGRP(4), .HOLD(3), .GAP(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  dffsnq_preset_sequencer #(.NGRP(4), .HOLD(1), .GAP(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input int i);
    if (rst) begin
      mode[i] = 0;
      t[i]    = 0;
    end else begin
      case (mode[i])
        0: if (req) begin
          mode[i] = 1;
          t[i]    = 0;
        end
        1: begin
          t[i]++;
          if (t[i] == ngrp * (hold[i] + gap[i])) mode[i] = 2;
        end
        default: if (!req) mode[i] = 0;
      endcase
    end
  endtask

  task automatic compare_dut(input int i, input logic [3:0] s, input logic a,
                             input logic b, input logic ce, input logic [3:0] cg);
    logic [3:0] e_setn;
    logic       e_ack, e_busy, e_ce;
    int         e_cg, period, g, p;
    e_setn = 4'hF;
    e_ack  = 1'b0;
    e_busy = 1'b0;
    e_ce   = 1'b1;
    e_cg   = 0;
    if (mode[i] == 1) begin
      period = hold[i] + gap[i];
      g      = t[i] / period;
      p      = t[i] % period;
      if (p < hold[i]) e_setn[g] = 1'b0;
      e_busy = 1'b1;
      e_ce   = 1'b0;
      e_cg   = g;
    end else if (mode[i] == 2) begin
      e_ack = 1'b1;
    end
    check($sformatf("d%0d setn", i),    32'(s),  32'(e_setn));
    check($sformatf("d%0d ack", i),     32'(a),  32'(e_ack));
    check($sformatf("d%0d busy", i),    32'(b),  32'(e_busy));
    check($sformatf("d%0d clk_en", i),  32'(ce), 32'(e_ce));
    check($sformatf("d%0d cur_grp", i), 32'(cg), 32'(e_cg));
    check($sformatf("d%0d one_low", i), 32'($countones(~s) <= 1), 32'd1);
    check($sformatf("d%0d low_idle", i), 32'((s != 4'hF) && !b), 32'd0);
    check($sformatf("d%0d ack_busy", i), 32'(a && b), 32'd0);
  endtask

  task automatic compare_all();
    compare_dut(0, bus0.setn, bus0.ack, bus0.busy, bus0.clk_en, bus0.cur_grp);
    compare_dut(1, bus1.setn, bus1.ack, bus1.busy, bus1.clk_en, bus1.cur_grp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic run_latency(input string tag);
    int lat0, lat1;
    lat0 = -1;
    lat1 = -1;
    req  = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus0.ack && lat0 < 0) lat0 = n - 1;
      if (bus1.ack && lat1 < 0) lat1 = n - 1;
    end
    check({tag, " lat0"}, 32'(lat0), 32'd20);
    check({tag, " lat1"}, 32'(lat1), 32'd4);
  endtask

  initial begin
    mode = '{0, 0};
    t    = '{0, 0};
    #1 rst = 1'b1;
    #1 compare_all();
    for (int n = 0; n < 3; n++) tick();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) tick();

    // full sequence, held through DONE, then a second identical sequence
    run_latency("seq1");
    req = 1'b0;
    for (int n = 0; n < 3; n++) tick();
    run_latency("seq2");
    req = 1'b0;
    for (int n = 0; n < 3; n++) tick();

    // single-cycle request pulse still runs the whole sequence
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int n = 0; n < 30; n++) tick();

    // asynchronous reset just after group 2 starts, REQ kept high
    req = 1'b1;
    for (int n = 0; n < 40 && !(mode[0] == 1 && t[0] == 9); n++) tick();
    check("reach grp2", 32'(mode[0] == 1 && t[0] == 9), 32'd1);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #2 rst = 1'b1;
    mode = '{0, 0};
    t    = '{0, 0};
    #1 compare_all();
    @(negedge clk);
    compare_all();
    tick();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 25; n++) tick();
    check("restart ack", 32'(bus0.ack), 32'd1);
    req = 1'b0;
    for (int n = 0; n < 3; n++) tick();

    // random REQ toggling
    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(0, 7) == 0) req = ~req;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
